// File: rtl/latch_sched_pkg.sv
// Shared types and timing defaults for the latch write scheduler.
// Sized so the one phase counter can hold the longest setup/enable/hold phase.
package latch_sched_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StEnable,
      StHold
   } sched_state_e;

   localparam int unsigned DefSetupCyc = 1;
   localparam int unsigned DefEnCyc    = 2;
   localparam int unsigned DefHoldCyc  = 1;

   function automatic int unsigned cnt_width(input int unsigned setup_cyc,
                                             input int unsigned en_cyc,
                                             input int unsigned hold_cyc);
      int unsigned m;
      m = setup_cyc;
      if (en_cyc > m) m = en_cyc;
      if (hold_cyc > m) m = hold_cyc;
      return (m < 1) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping around, wins.
module rr_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IdW    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IdW-1:0]     ptr_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IdW-1:0]     idx_o,
   output logic               any_o
);

   logic [IdW:0] j;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      j     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = {1'b0, ptr_i} + (IdW + 1)'(k);
         if (j >= (IdW + 1)'(NUM_REQ)) j = j - (IdW + 1)'(NUM_REQ);
         if (!any_o && req_i[j[IdW-1:0]]) begin
            any_o                = 1'b1;
            gnt_o[j[IdW-1:0]]    = 1'b1;
            idx_o                = j[IdW-1:0];
         end
      end
   end

endmodule

// File: rtl/latch_wr_sched.sv
// Write scheduler for a shared bank of level-sensitive latches: round-robin
// accept, then setup / enable pulse / hold so D is stable around every En window.
module latch_wr_sched
   import latch_sched_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned NUM_LATCH = 8,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned ADDR_W    = 3,
   parameter int unsigned SETUP_CYC = DefSetupCyc,
   parameter int unsigned EN_CYC    = DefEnCyc,
   parameter int unsigned HOLD_CYC  = DefHoldCyc
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req_valid,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [DATA_W-1:0]           lat_D,
   output logic [NUM_LATCH-1:0]        lat_En,
   output logic                        busy,
   output logic                        done,
   output logic [$clog2(NUM_REQ)-1:0]  done_id,
   output logic                        addr_err
);

   localparam int unsigned IdW     = $clog2(NUM_REQ);
   localparam int unsigned CntW    = cnt_width(SETUP_CYC, EN_CYC, HOLD_CYC);
   localparam logic        HoldOne = (HOLD_CYC == 1);

   sched_state_e          state_q;
   logic [CntW-1:0]       cnt_q;
   logic [IdW-1:0]        ptr_q;
   logic [IdW-1:0]        id_q;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     data_q;
   logic [NUM_LATCH-1:0]  en_q;
   logic                  done_q;
   logic                  err_q;

   logic [NUM_REQ-1:0]    gnt;
   logic [IdW-1:0]        gnt_idx;
   logic                  gnt_any;
   logic [NUM_LATCH-1:0]  addr_dec;
   logic [IdW-1:0]        ptr_next;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .req_i (req_valid),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   // An out-of-range captured address decodes to all zeros, which doubles as the error flag.
   always_comb begin
      addr_dec = '0;
      for (int i = 0; i < NUM_LATCH; i++) begin
         if (addr_q == ADDR_W'(i)) addr_dec[i] = 1'b1;
      end
   end

   always_comb begin
      ptr_next = gnt_idx + IdW'(1);
      if (gnt_idx == IdW'(NUM_REQ - 1)) ptr_next = '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         ptr_q   <= '0;
         id_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         en_q    <= '0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (gnt_any) begin
                  addr_q  <= req_addr[gnt_idx*ADDR_W +: ADDR_W];
                  data_q  <= req_data[gnt_idx*DATA_W +: DATA_W];
                  id_q    <= gnt_idx;
                  ptr_q   <= ptr_next;
                  cnt_q   <= CntW'(SETUP_CYC - 1);
                  state_q <= StSetup;
               end
            end
            StSetup: begin
               if (cnt_q == '0) begin
                  en_q    <= addr_dec;
                  cnt_q   <= CntW'(EN_CYC - 1);
                  state_q <= StEnable;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StEnable: begin
               if (cnt_q == '0) begin
                  en_q    <= '0;
                  cnt_q   <= CntW'(HOLD_CYC - 1);
                  done_q  <= HoldOne;
                  err_q   <= HoldOne & ~|addr_dec;
                  state_q <= StHold;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
               end
            end
            StHold: begin
               if (cnt_q == '0) begin
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  state_q <= StIdle;
               end else begin
                  cnt_q <= cnt_q - CntW'(1);
                  // Raise done one cycle early so it is registered in the final hold cycle.
                  if (cnt_q == CntW'(1)) begin
                     done_q <= 1'b1;
                     err_q  <= ~|addr_dec;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign req_ready = (state_q == StIdle) ? gnt : '0;
   assign lat_D     = data_q;
   assign lat_En    = en_q;
   assign busy      = (state_q != StIdle);
   assign done      = done_q;
   assign done_id   = id_q;
   assign addr_err  = err_q;

endmodule

// File: tb/tb_latch_wr_sched.sv
// Randomized and directed bench for latch_wr_sched against a transaction-timeline model.
module tb_latch_wr_sched;

   localparam int NR = 4;
   localparam int NL = 6;
   localparam int DW = 8;
   localparam int AW = 3;
   localparam int S  = 1;
   localparam int E  = 2;
   localparam int H  = 1;
   localparam int L  = S + E + H;
   localparam int IW = 2;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req_valid;
   logic [NR-1:0]    req_ready;
   logic [NR*AW-1:0] req_addr;
   logic [NR*DW-1:0] req_data;
   logic [DW-1:0]    lat_D;
   logic [NL-1:0]    lat_En;
   logic             busy;
   logic             done;
   logic [IW-1:0]    done_id;
   logic             addr_err;

   latch_wr_sched #(
      .NUM_REQ   (NR),
      .NUM_LATCH (NL),
      .DATA_W    (DW),
      .ADDR_W    (AW),
      .SETUP_CYC (S),
      .EN_CYC    (E),
      .HOLD_CYC  (H)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .lat_D     (lat_D),
      .lat_En    (lat_En),
      .busy      (busy),
      .done      (done),
      .done_id   (done_id),
      .addr_err  (addr_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // Model: m_t is the cycle number within the current write (0 = idle, 1..L in flight).
   int          m_t;
   int          m_ptr;
   int          m_addr;
   int          m_id;
   logic [DW-1:0] m_d;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t    = 0;
      m_ptr  = 0;
      m_addr = 0;
      m_id   = 0;
      m_d    = '0;
   endtask

   function automatic int m_grant();
      for (int k = 0; k < NR; k++) begin
         if (req_valid[(m_ptr + k) % NR]) return (m_ptr + k) % NR;
      end
      return -1;
   endfunction

   task automatic check_outputs(output int g);
      logic [NR-1:0] exp_rdy;
      logic [NL-1:0] exp_en;
      g       = (m_t == 0) ? m_grant() : -1;
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_en = '0;
      if (m_t > S && m_t <= S + E && m_addr < NL) exp_en[m_addr] = 1'b1;
      check("req_ready", req_ready, exp_rdy);
      check("lat_En", lat_En, exp_en);
      check("lat_D", lat_D, m_d);
      check("busy", busy, m_t != 0);
      check("done", done, m_t == L);
      check("addr_err", addr_err, (m_t == L) && (m_addr >= NL));
      if (m_t != 0) check("done_id", done_id, m_id);
   endtask

   // One clock: check pre-edge outputs at negedge, then advance the model across the edge.
   task automatic step(output int g);
      int          a;
      logic [DW-1:0] d;
      @(negedge clk);
      check_outputs(g);
      a = 0;
      d = '0;
      if (g >= 0) begin
         a = int'(req_addr[g*AW +: AW]);
         d = req_data[g*DW +: DW];
      end
      @(posedge clk);
      if (g >= 0) begin
         m_addr = a;
         m_d    = d;
         m_id   = g;
         m_ptr  = (g + 1) % NR;
         m_t    = 1;
      end else if (m_t != 0) begin
         m_t = (m_t == L) ? 0 : m_t + 1;
      end
      #1;
   endtask

   task automatic run(input int n);
      int g;
      for (int i = 0; i < n; i++) step(g);
   endtask

   logic [NL-1:0] prev_en;
   logic [DW-1:0] prev_d;

   always @(negedge clk) begin
      if (rst_n) begin
         check("en_onehot", $countones(lat_En) <= 1, 1'b1);
         if (prev_en != '0 && lat_En != '0) check("d_stable_en", lat_D, prev_d);
      end
      prev_en = lat_En;
      prev_d  = lat_D;
   end

   initial begin
      int g;
      rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      model_reset();
      #1;
      check("rst_En", lat_En, 0);
      check("rst_D", lat_D, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", addr_err, 0);
      check("rst_id", done_id, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      run(2);

      // Single write with data changed right after the transfer.
      req_valid = 4'b0001;
      req_addr[0 +: AW] = 3'd3;
      req_data[0 +: DW] = 8'hA5;
      step(g);
      check("single_grant", g, 0);
      req_valid = '0;
      req_data[0 +: DW] = 8'h3C;
      run(L + 2);

      // Reset in the middle of the enable window; pointer was 1 before reset.
      req_valid = 4'b0001;
      req_addr[0 +: AW] = 3'd5;
      step(g);
      req_valid = '0;
      run(S + 1);
      check("pre_rst_En", lat_En, 6'h20);
      rst_n = 1'b0;
      #1;
      check("async_rst_En", lat_En, 0);
      check("async_rst_busy", busy, 0);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      req_valid = 4'b0011;
      step(g);
      check("post_rst_prio", g, 0);
      req_valid = '0;
      run(L + 1);

      // Priority wrap: serve requester 2, then 0 and 2 compete.
      req_valid = 4'b0100;
      req_addr[2*AW +: AW] = 3'd2;
      step(g);
      req_valid = '0;
      run(L);
      req_valid = 4'b0101;
      step(g);
      check("wrap_grant", g, 0);
      req_valid = '0;
      run(L + 1);

      // Out-of-range addresses 6 and 7.
      req_valid = 4'b0010;
      req_addr[AW +: AW] = 3'd7;
      run(L + 2);
      req_addr[AW +: AW] = 3'd6;
      run(L + 2);
      req_valid = '0;
      run(L + 1);

      // All requesters continuously valid.
      req_valid = 4'hF;
      req_addr  = {3'd3, 3'd2, 3'd1, 3'd0};
      run(5 * L + 7);
      req_valid = '0;
      run(L + 1);

      // Random traffic.
      for (int i = 0; i < 600; i++) begin
         req_valid = ($urandom_range(0, 3) == 0) ? '0 : NR'($urandom);
         req_addr  = (NR*AW)'($urandom);
         req_data  = (NR*DW)'($urandom);
         step(g);
      end
      req_valid = '0;
      run(L + 2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
